std_fifo: RTL and testbench
===========================

STD_FIFO -- requirements
Module: std_fifo

Interface
REQ-001 The module SHALL declare parameter WIDTH, default 32, data word width in bits.
REQ-002 The module SHALL declare parameter DEPTH, default 32, number of entries, power of two and at least 2.
REQ-003 The module SHALL declare parameter ALMOST_FULL_COUNT, default 1, free-entry threshold for almost_full.
REQ-004 The module SHALL declare parameter ALMOST_EMPTY_COUNT, default 1, occupancy threshold for almost_empty.
REQ-005 The module SHALL declare parameter LATENCY, default 1, read latency, legal values 0 and 1.
REQ-006 The module SHALL have ports in this positional order: rst, clk, push, pop, d, q, full, empty, count, almost_empty, almost_full.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 push  input  1  write d this cycle.
REQ-010 pop  input  1  remove head entry this cycle.
REQ-011 d  input  WIDTH  write data.
REQ-012 q  output  WIDTH  read data.
REQ-013 full  output  1  count equals DEPTH.
REQ-014 empty  output  1  count equals 0.
REQ-015 count  output  log2(DEPTH)+1  current occupancy.
REQ-016 almost_empty  output  1  count <= ALMOST_EMPTY_COUNT.
REQ-017 almost_full  output  1  count >= DEPTH - ALMOST_FULL_COUNT.

Function
REQ-018 Storage SHALL be a DEPTH-entry circular buffer with log2(DEPTH)-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-019 Push SHALL be accepted when !full, or when full and an accepted pop occurs in the same cycle; a push to a full FIFO with no pop SHALL be dropped with no state change.
REQ-020 Pop SHALL be accepted only when !empty; a pop on an empty FIFO SHALL be ignored, including when push is high in the same cycle.
REQ-021 count SHALL increment on an accepted push alone, decrement on an accepted pop alone, and hold when both are accepted.
REQ-022 full, empty, almost_full, almost_empty and count SHALL be registered and consistent with count after the clock edge.
REQ-023 LATENCY=1: q SHALL be a register loaded with the head entry on an accepted pop, valid from the next cycle, and held until the next accepted pop.
REQ-024 LATENCY=0: q SHALL combinationally present the head entry while !empty (first-word fall-through), so the consumer samples q in the same cycle it asserts pop; q SHALL be 0 while empty.
REQ-025 Data SHALL leave the FIFO in exact push order, with no loss or duplication across pointer wrap.
REQ-026 A pushed word SHALL NOT be visible on q (LATENCY=0) or poppable until the cycle after its push; this is one cycle of write-to-read latency.

Reset
REQ-027 While rst is high at a clock edge, the pointers and count SHALL clear to 0, empty SHALL be 1, full, almost_full and almost_empty SHALL follow count=0, and the LATENCY=1 q register SHALL clear to 0.
REQ-028 A reset during push or pop activity SHALL discard all contents; push and pop in the reset cycle SHALL be ignored.
REQ-029 Storage RAM contents SHALL NOT require reset.

Configuration
REQ-030 With macro STD_FIFO_ASSERT_EN defined, the module SHALL print a simulation error message (with %m) on each dropped push or ignored pop.
REQ-031 Without STD_FIFO_ASSERT_EN, no checking logic or messages SHALL be compiled in; functional behaviour SHALL be identical.

Verification
REQ-032 Fill/drain: DEPTH=32, LATENCY=1, push 0..31 -> full=1 after 32nd push; pop 32 times -> q shows 0..31 each one cycle after its pop; empty=1 at end.
REQ-033 FWFT: LATENCY=0, push 0xA then 0xB -> q=0xA the cycle after the first push; pop -> q=0xB next cycle; pop -> empty=1, q=0.
REQ-034 Thresholds: DEPTH=32, ALMOST_FULL_COUNT=8 -> almost_full rises when count reaches 24 and falls when count drops to 23.
REQ-035 Boundaries: push while full without pop -> count stays 32 and data is unchanged; push+pop while full -> count stays 32 and order is preserved; pop while empty -> no change.
REQ-036 Wrap: push and pop 100 words in an interleaved pattern with DEPTH=32 -> output sequence equals input sequence.
REQ-037 Reset mid-stream: with count=5, assert rst for one cycle -> count=0, empty=1, q=0; the next push then pop returns the new word.

Source files
------------

// File: rtl/std_fifo.sv
// std_fifo -- single-clock circular-buffer FIFO with registered status flags.
//
// Purpose:
//   DEPTH-entry FIFO of WIDTH-bit words. Occupancy and all status flags are
//   registered. The read port is either a registered output loaded on pop
//   (LATENCY=1) or a first-word fall-through view of the head (LATENCY=0).
//
// Ports:
//   rst          in   synchronous active-high reset
//   clk          in   clock, all state updates on the rising edge
//   push         in   write d this cycle
//   pop          in   remove the head entry this cycle
//   d            in   [WIDTH-1:0] write data
//   q            out  [WIDTH-1:0] read data
//   full         out  count == DEPTH
//   empty        out  count == 0
//   count        out  [log2(DEPTH):0] current occupancy
//   almost_empty out  count <= ALMOST_EMPTY_COUNT
//   almost_full  out  count >= DEPTH - ALMOST_FULL_COUNT
//
// Optional feature:
//   STD_FIFO_ASSERT_EN -- when defined, prints a simulation error (with %m)
//   for every dropped push and every ignored pop. Absent by default.

module std_fifo #(
  parameter int WIDTH              = 32,
  parameter int DEPTH              = 32,
  parameter int ALMOST_FULL_COUNT  = 1,
  parameter int ALMOST_EMPTY_COUNT = 1,
  parameter int LATENCY            = 1
) (
  input  logic                     rst,
  input  logic                     clk,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         q,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_empty,
  output logic                     almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          almostFull_q, almostFull_d;
  logic          almostEmpty_q, almostEmpty_d;

  logic popOk;
  logic pushOk;

  // A pop needs a stored word; a push into a full FIFO is only legal when
  // the same cycle's pop frees the slot it will reuse.
  assign popOk  = pop && !empty_q;
  assign pushOk = push && (!full_q || popOk);

  // Next-state for pointers and occupancy; flags are derived from the new
  // count so they are already consistent with it once registered.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (popOk) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    if (pushOk && !popOk) begin
      count_d = count_q + CW'(1);
    end else if (popOk && !pushOk) begin
      count_d = count_q - CW'(1);
    end
    full_d        = (count_d == CW'(DEPTH));
    empty_d       = (count_d == '0);
    almostFull_d  = (count_d >= CW'(DEPTH - ALMOST_FULL_COUNT));
    almostEmpty_d = (count_d <= CW'(ALMOST_EMPTY_COUNT));
  end

  // Control state; reset returns to the empty condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almostFull_q  <= (CW'(0) >= CW'(DEPTH - ALMOST_FULL_COUNT));
      almostEmpty_q <= 1'b1;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      almostFull_q  <= almostFull_d;
      almostEmpty_q <= almostEmpty_d;
    end
  end

  // Storage has no reset. On push+pop while full both pointers address the
  // same slot; the read sees the old word because the write lands at the edge.
  always_ff @(posedge clk) begin
    if (!rst && pushOk) begin
      mem[wrPtr_q] <= d;
    end
  end

  generate
    if (LATENCY == 1) begin : gLatency1
      logic [WIDTH-1:0] qReg_q;

      // Registered read port: captures the head on each accepted pop and
      // holds it until the next one.
      always_ff @(posedge clk) begin
        if (rst) begin
          qReg_q <= '0;
        end else if (popOk) begin
          qReg_q <= mem[rdPtr_q];
        end
      end

      assign q = qReg_q;
    end else begin : gLatency0
      // Fall-through: head is visible while anything is stored, zero otherwise.
      assign q = empty_q ? '0 : mem[rdPtr_q];
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign count        = count_q;
  assign almost_full  = almostFull_q;
  assign almost_empty = almostEmpty_q;

`ifdef STD_FIFO_ASSERT_EN
  // Misuse reporting only; does not affect the datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push && !pushOk) begin
        $error("%m: push dropped, FIFO full");
      end
      if (pop && empty_q) begin
        $error("%m: pop ignored, FIFO empty");
      end
    end
  end
`endif

endmodule

// File: tb/tb_std_fifo.sv
// tb_std_fifo -- drives a LATENCY=1 and a LATENCY=0 std_fifo with identical
// directed stimulus. A queue-based reference model predicts every output and
// is compared on each falling edge; literal expectations pin key points.

module tb_std_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 32;
  localparam int AFC   = 8;
  localparam int AEC   = 1;

  logic          clk;
  logic          rst;
  logic          push;
  logic          pop;
  logic [W-1:0]  d;

  logic [W-1:0]  q1, q0;
  logic          full1, full0, empty1, empty0;
  logic          af1, af0, ae1, ae0;
  logic [5:0]    count1, count0;

  int checks;
  int passed;
  bit checkEn;

  // Reference model state.
  logic [W-1:0] mq[$];
  logic [W-1:0] mqReg;

  std_fifo #(.WIDTH(W), .DEPTH(DEPTH), .ALMOST_FULL_COUNT(AFC),
             .ALMOST_EMPTY_COUNT(AEC), .LATENCY(1)) dutL1 (
    .rst(rst), .clk(clk), .push(push), .pop(pop), .d(d), .q(q1),
    .full(full1), .empty(empty1), .count(count1),
    .almost_empty(ae1), .almost_full(af1)
  );

  std_fifo #(.WIDTH(W), .DEPTH(DEPTH), .ALMOST_FULL_COUNT(AFC),
             .ALMOST_EMPTY_COUNT(AEC), .LATENCY(0)) dutL0 (
    .rst(rst), .clk(clk), .push(push), .pop(pop), .d(d), .q(q0),
    .full(full0), .empty(empty0), .count(count0),
    .almost_empty(ae0), .almost_full(af0)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison; logs a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance the model by the rules of
  // acceptance: pop needs a stored word, push needs room or a same-cycle pop.
  task automatic applyStimulus(input logic r, input logic p, input logic o,
                               input logic [W-1:0] data);
    bit popOk;
    bit pushOk;
    rst  = r;
    push = p;
    pop  = o;
    d    = data;
    @(posedge clk);
    if (r) begin
      mq.delete();
      mqReg = '0;
    end else begin
      popOk  = o && (mq.size() > 0);
      pushOk = p && ((mq.size() < DEPTH) || popOk);
      if (popOk) mqReg = mq.pop_front();
      if (pushOk) mq.push_back(data);
    end
    #1;
  endtask

  // Every falling edge: both DUTs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      int n;
      logic [W-1:0] head;
      n    = mq.size();
      head = (n > 0) ? mq[0] : '0;
      checkOutput("cmp.count1", W'(count1), W'(n));
      checkOutput("cmp.count0", W'(count0), W'(n));
      checkOutput("cmp.full1",  W'(full1),  W'(n == DEPTH));
      checkOutput("cmp.full0",  W'(full0),  W'(n == DEPTH));
      checkOutput("cmp.empty1", W'(empty1), W'(n == 0));
      checkOutput("cmp.empty0", W'(empty0), W'(n == 0));
      checkOutput("cmp.af1",    W'(af1),    W'(n >= DEPTH - AFC));
      checkOutput("cmp.af0",    W'(af0),    W'(n >= DEPTH - AFC));
      checkOutput("cmp.ae1",    W'(ae1),    W'(n <= AEC));
      checkOutput("cmp.ae0",    W'(ae0),    W'(n <= AEC));
      checkOutput("cmp.q1",     q1,         mqReg);
      checkOutput("cmp.q0",     q0,         head);
    end
  end

  initial begin
    int idx;
    checks  = 0;
    passed  = 0;
    checkEn = 1'b0;
    mqReg   = '0;
    rst     = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    d       = '0;

    // Reset state.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkEn = 1'b1;
    checkOutput("rst.count", W'(count1), 32'd0);
    checkOutput("rst.empty", W'(empty1), 32'd1);
    checkOutput("rst.full",  W'(full1),  32'd0);
    checkOutput("rst.ae",    W'(ae1),    32'd1);
    checkOutput("rst.af",    W'(af1),    32'd0);
    checkOutput("rst.q1",    q1,         32'd0);
    checkOutput("rst.q0",    q0,         32'd0);

    // First-word fall-through sequence.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hA);
    checkOutput("fwft.firstQ0", q0, 32'hA);
    checkOutput("fwft.count",   W'(count0), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hB);
    checkOutput("fwft.holdQ0",  q0, 32'hA);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("fwft.nextQ0",  q0, 32'hB);
    checkOutput("fwft.popQ1",   q1, 32'hA);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("fwft.empty",   W'(empty0), 32'd1);
    checkOutput("fwft.zeroQ0",  q0, 32'd0);
    checkOutput("fwft.lastQ1",  q1, 32'hB);

    // Fill to full, watching almost_full rise at 24.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, W'(i));
      if (i == 22) checkOutput("fill.af23", W'(af1), 32'd0);
      if (i == 23) checkOutput("fill.af24", W'(af1), 32'd1);
    end
    checkOutput("fill.full",  W'(full1),  32'd1);
    checkOutput("fill.count", W'(count1), 32'd32);
    checkOutput("fill.headQ0", q0, 32'd0);

    // Push into full FIFO with no pop is dropped.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'hDEAD);
    checkOutput("ovf.count", W'(count1), 32'd32);
    checkOutput("ovf.headQ0", q0, 32'd0);

    // Push and pop together while full.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h99);
    checkOutput("fullpp.count", W'(count1), 32'd32);
    checkOutput("fullpp.q1", q1, 32'd0);
    checkOutput("fullpp.q0", q0, 32'd1);

    // Drain: contents are 1..31 then 0x99.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
      if (i == 0)  checkOutput("drain.firstQ1", q1, 32'd1);
      if (i == 7)  checkOutput("drain.af24", W'(af1), 32'd1);
      if (i == 8)  checkOutput("drain.af23", W'(af1), 32'd0);
      if (i == 29) checkOutput("drain.ae2",  W'(ae1), 32'd0);
      if (i == 30) checkOutput("drain.ae1",  W'(ae1), 32'd1);
    end
    checkOutput("drain.lastQ1", q1, 32'h99);
    checkOutput("drain.empty", W'(empty1), 32'd1);

    // Pop on empty is ignored, alone and alongside a push.
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("udf.count", W'(count1), 32'd0);
    checkOutput("udf.q1", q1, 32'h99);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h77);
    checkOutput("udfpp.count", W'(count1), 32'd1);
    checkOutput("udfpp.q1", q1, 32'h99);
    checkOutput("udfpp.q0", q0, 32'h77);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("udfpp.popQ1", q1, 32'h77);

    // Interleaved traffic of 100 words across several pointer wraps.
    idx = 0;
    for (int k = 0; k < 140; k++) begin
      logic p;
      p = (idx < 100);
      applyStimulus(1'b0, p, (k % 4) != 0, 32'h1000 + W'(idx));
      if (p) idx++;
    end
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
    end
    checkOutput("wrap.lastQ1", q1, 32'h1063);
    checkOutput("wrap.empty", W'(empty1), 32'd1);

    // Reset mid-stream with push and pop active.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h200 + W'(i));
    end
    checkOutput("midrst.pre", W'(count1), 32'd5);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hBAD);
    checkOutput("midrst.count", W'(count1), 32'd0);
    checkOutput("midrst.empty", W'(empty1), 32'd1);
    checkOutput("midrst.q1", q1, 32'd0);
    checkOutput("midrst.q0", q0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h55);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("midrst.newQ1", q1, 32'h55);

    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
